// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared types and constants for the boot-time instruction loader.
//   state_e        : loader FSM states
//   NOP_WORD       : all-zero MIPS instruction (sll $0,$0,0); also the
//                    power-on value of the write-data register
//   BYTES_PER_WORD : stream bytes packed into one instruction word
package program_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      RUN   = 2'd3
   } state_e;

   localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
   localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_word_packer.sv
// word_packer
//   Packs a byte stream big-endian into 32-bit words.
//   clk, reset  : clock, synchronous active-low reset
//   clr         : drop any partial word and restart at byte index 0
//   push        : byte_in is taken this cycle
//   byte_in     : stream byte
//   word_ready  : this push completes a 4-byte word
//   partial     : this push leaves the word incomplete (fewer than 4 bytes)
//   word        : bytes gathered so far plus byte_in, left-aligned, low
//                 bytes zero-filled; equals the full word when word_ready
import program_loader_pkg::*;

module word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        push,
   input  logic [7:0]  byte_in,
   output logic        word_ready,
   output logic        partial,
   output logic [31:0] word
);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] acc_q, acc_d;
   logic [4:0]  shamt;

   // Accumulator holds earlier bytes right-aligned with zeros above, so
   // shifting {acc, byte_in} left by 8*(3-idx) gives the padded word.
   assign shamt      = {~idx_q, 3'b000};
   assign word       = {acc_q, byte_in} << shamt;
   assign word_ready = push && (idx_q == 2'(BYTES_PER_WORD - 1));
   assign partial    = push && (idx_q != 2'(BYTES_PER_WORD - 1));

   always_comb begin
      idx_d = idx_q;
      acc_d = acc_q;
      if (clr) begin
         idx_d = '0;
         acc_d = '0;
      end else if (push) begin
         if (word_ready) begin
            // word leaves this cycle; next byte can be taken immediately
            idx_d = '0;
            acc_d = '0;
         end else begin
            idx_d = idx_q + 2'd1;
            acc_d = {acc_q[15:0], byte_in};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q <= '0;
         acc_q <= '0;
      end else begin
         idx_q <= idx_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Loads a byte stream into instruction memory as big-endian words at
//   consecutive addresses from 0, holding the CPU in reset meanwhile.
//   clk, reset         : clock, synchronous active-low reset
//   start              : pulse; begins a new load from IDLE or RUN
//   byte_in/valid/last : stream input; byte_ready is the accept handshake
//   mem_we/addr/wdata  : registered instruction-memory write port
//   cpu_hold           : active-high CPU reset; low only in RUN
//   done               : load finished, CPU running
//   err_overflow       : sticky; program larger than MEM_BYTES
//   word_count         : words written in the current load
import program_loader_pkg::*;

module program_loader #(
   parameter int MEM_BYTES = 512,
   parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err_overflow,
   output logic [ADDR_W-2:0] word_count
);

   localparam logic [ADDR_W-2:0] MEM_WORDS = (ADDR_W-1)'(MEM_BYTES / BYTES_PER_WORD);

   state_e            state_q, state_d;
   logic              byte_ready_q, byte_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W-2:0] word_count_q, word_count_d;
   // Address of the next write; advances with the write strobe itself,
   // while the visible word_count trails it by one cycle.
   logic [ADDR_W-2:0] wr_cnt_q, wr_cnt_d;

   logic        accept, start_load, pk_clr;
   logic        pk_ready, pk_partial;
   logic [31:0] pk_word;

   assign accept     = byte_valid && byte_ready_q;
   assign start_load = start && ((state_q == IDLE) || (state_q == RUN));
   assign pk_clr     = start_load || (accept && byte_last);

   word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr        (pk_clr),
      .push       (accept),
      .byte_in    (byte_in),
      .word_ready (pk_ready),
      .partial    (pk_partial),
      .word       (pk_word)
   );

   always_comb begin
      state_d      = state_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      wr_cnt_d     = wr_cnt_q;
      err_d        = err_q;
      word_count_d = wr_cnt_q;

      case (state_q)
         IDLE, RUN: begin
            if (start_load) begin
               state_d      = LOAD;
               wr_cnt_d     = '0;
               word_count_d = '0;
               err_d        = 1'b0;
            end
         end
         LOAD: begin
            if (accept) begin
               // A final partial word is registered now so its write
               // lands in the FLUSH cycle, same as a completed word.
               if (pk_ready || (pk_partial && byte_last)) begin
                  if (wr_cnt_q == MEM_WORDS) begin
                     err_d = 1'b1;
                  end else begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = {wr_cnt_q[ADDR_W-3:0], 2'b00};
                     mem_wdata_d = pk_word;
                     wr_cnt_d    = wr_cnt_q + (ADDR_W-1)'(1);
                  end
               end
               if (byte_last) state_d = FLUSH;
            end
         end
         FLUSH:   state_d = RUN;
         default: state_d = IDLE;
      endcase

      byte_ready_d = (state_d == LOAD);
      cpu_hold_d   = (state_d != RUN);
      done_d       = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= NOP_WORD;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         word_count_q <= '0;
         wr_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         err_q        <= err_d;
         word_count_q <= word_count_d;
         wr_cnt_q     <= wr_cnt_d;
      end
   end

   assign byte_ready   = byte_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign err_overflow = err_q;
   assign word_count   = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench. Two loaders share the stimulus: dut_a at full size
//   (512 bytes) and dut_b shrunk to 16 bytes for the overflow cases.
module tb_program_loader;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [7:0] byte_in = '0;
   logic byte_valid = 1'b0;
   logic byte_last = 1'b0;

   logic        rdy_a, we_a, hold_a, done_a, err_a;
   logic [8:0]  addr_a;
   logic [31:0] data_a;
   logic [7:0]  wc_a;
   logic        rdy_b, we_b, hold_b, done_b, err_b;
   logic [3:0]  addr_b;
   logic [31:0] data_b;
   logic [2:0]  wc_b;

   int n_cmp = 0;
   int n_bad = 0;

   // write logs captured on the falling edge
   int          na = 0, nb = 0;
   logic [8:0]  la_addr [0:15];
   logic [31:0] la_data [0:15];
   logic [3:0]  lb_addr [0:15];
   logic [31:0] lb_data [0:15];

   always #5 clk = ~clk;

   program_loader #(.MEM_BYTES(512), .ADDR_W(9)) dut_a (
      .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(rdy_a),
      .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(data_a),
      .cpu_hold(hold_a), .done(done_a), .err_overflow(err_a), .word_count(wc_a)
   );

   program_loader #(.MEM_BYTES(16), .ADDR_W(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(rdy_b),
      .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(data_b),
      .cpu_hold(hold_b), .done(done_b), .err_overflow(err_b), .word_count(wc_b)
   );

   always @(negedge clk) begin
      if (we_a) begin
         if (na < 16) begin la_addr[na] = addr_a; la_data[na] = data_a; end
         na++;
      end
      if (we_b) begin
         if (nb < 16) begin lb_addr[nb] = addr_b; lb_data[nb] = data_b; end
         nb++;
      end
   end

   task automatic step();
      @(posedge clk); @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   // present one byte for one clock; returns on the following falling edge
   task automatic send(input logic [7:0] b, input logic last);
      byte_in = b; byte_valid = 1'b1; byte_last = last;
      step();
      byte_valid = 1'b0; byte_last = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; step(); step(); step();
      n_cmp++; if (hold_a !== 1'b1) begin n_bad++; $display("FAIL reset_hold got %b exp 1", hold_a); end
      n_cmp++; if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b exp 0", rdy_a); end
      n_cmp++; if ({we_a, done_a, err_a} !== 3'b000) begin n_bad++; $display("FAIL reset_we_done_err got %b exp 000", {we_a, done_a, err_a}); end
      n_cmp++; if ({addr_a, data_a, wc_a} !== '0) begin n_bad++; $display("FAIL reset_addr_data_wc got %h/%h/%h exp 0/0/0", addr_a, data_a, wc_a); end
      reset = 1'b1; step();
      n_cmp++; if (hold_a !== 1'b1 || rdy_a !== 1'b0) begin n_bad++; $display("FAIL idle_hold_ready got %b%b exp 10", hold_a, rdy_a); end
   endtask

   task automatic test_two_words();
      logic [7:0] bytes [0:7] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
      pulse_start(); na = 0;
      n_cmp++; if (rdy_a !== 1'b1 || hold_a !== 1'b1) begin n_bad++; $display("FAIL load_entry ready/hold got %b%b exp 11", rdy_a, hold_a); end
      for (int i = 0; i < 4; i++) send(bytes[i], 1'b0);
      // write visible one cycle after the 4th accept; count not yet bumped
      n_cmp++; if ({we_a, addr_a, data_a} !== {1'b1, 9'd0, 32'h8C010004}) begin n_bad++; $display("FAIL w0_latency got we=%b @%h %h exp 1 @000 8c010004", we_a, addr_a, data_a); end
      n_cmp++; if (wc_a !== 8'd0) begin n_bad++; $display("FAIL w0_wc_lag got %0d exp 0", wc_a); end
      send(bytes[4], 1'b0);
      n_cmp++; if (wc_a !== 8'd1 || we_a !== 1'b0) begin n_bad++; $display("FAIL w0_wc_after got wc=%0d we=%b exp 1/0", wc_a, we_a); end
      for (int i = 5; i < 8; i++) send(bytes[i], i == 7);
      n_cmp++; if ({we_a, addr_a, data_a} !== {1'b1, 9'd4, 32'hAC020008}) begin n_bad++; $display("FAIL w1_flush got we=%b @%h %h exp 1 @004 ac020008", we_a, addr_a, data_a); end
      n_cmp++; if (hold_a !== 1'b1 || rdy_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL flush_state got hold=%b rdy=%b done=%b exp 1/0/0", hold_a, rdy_a, done_a); end
      step();
      n_cmp++; if (hold_a !== 1'b0 || done_a !== 1'b1) begin n_bad++; $display("FAIL run_state got hold=%b done=%b exp 0/1", hold_a, done_a); end
      n_cmp++; if (wc_a !== 8'd2 || we_a !== 1'b0) begin n_bad++; $display("FAIL run_wc got wc=%0d we=%b exp 2/0", wc_a, we_a); end
      n_cmp++; if (na !== 2) begin n_bad++; $display("FAIL two_words_count got %0d exp 2", na); end
   endtask

   task automatic test_padded();
      logic [7:0] bytes [0:5] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22};
      pulse_start(); na = 0;
      n_cmp++; if (hold_a !== 1'b1 || done_a !== 1'b0) begin n_bad++; $display("FAIL restart_from_run got hold=%b done=%b exp 1/0", hold_a, done_a); end
      for (int i = 0; i < 4; i++) send(bytes[i], 1'b0);
      // start and a lone byte_last are both ignored while loading
      start = 1'b1; byte_last = 1'b1; step(); start = 1'b0; byte_last = 1'b0;
      n_cmp++; if (rdy_a !== 1'b1 || wc_a !== 8'd1) begin n_bad++; $display("FAIL ignore_start_last got rdy=%b wc=%0d exp 1/1", rdy_a, wc_a); end
      send(bytes[4], 1'b0);
      send(bytes[5], 1'b1);
      n_cmp++; if ({we_a, addr_a, data_a} !== {1'b1, 9'd4, 32'h00220000}) begin n_bad++; $display("FAIL pad_flush got we=%b @%h %h exp 1 @004 00220000", we_a, addr_a, data_a); end
      step();
      n_cmp++; if (na !== 2 || la_addr[0] !== 9'd0 || la_data[0] !== 32'h20010005) begin n_bad++; $display("FAIL pad_w0 got n=%0d @%h %h exp 2 @000 20010005", na, la_addr[0], la_data[0]); end
      n_cmp++; if (done_a !== 1'b1 || wc_a !== 8'd2) begin n_bad++; $display("FAIL pad_run got done=%b wc=%0d exp 1/2", done_a, wc_a); end
   endtask

   task automatic test_gaps();
      logic [7:0] bytes [0:7] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
      int gaps [0:7] = '{2, 0, 1, 3, 0, 0, 2, 0};
      int not_ready = 0;
      pulse_start(); na = 0;
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gaps[i]; g++) begin
            if (rdy_a !== 1'b1) not_ready++;
            step();
         end
         if (rdy_a !== 1'b1) not_ready++;
         send(bytes[i], i == 7);
      end
      step();
      n_cmp++; if (not_ready !== 0) begin n_bad++; $display("FAIL gaps_ready got %0d low cycles exp 0", not_ready); end
      n_cmp++; if (na !== 2) begin n_bad++; $display("FAIL gaps_we_count got %0d exp 2", na); end
      n_cmp++; if ({la_addr[0], la_data[0], la_addr[1], la_data[1]} !== {9'd0, 32'h8C010004, 9'd4, 32'hAC020008}) begin n_bad++; $display("FAIL gaps_image got @%h %h @%h %h exp @000 8c010004 @004 ac020008", la_addr[0], la_data[0], la_addr[1], la_data[1]); end
   endtask

   task automatic test_overflow();
      pulse_start(); na = 0; nb = 0;
      for (int i = 0; i < 20; i++) send(8'(8'h10 + i), i == 19);
      n_cmp++; if (we_b !== 1'b0 || err_b !== 1'b1) begin n_bad++; $display("FAIL ovf_drop got we=%b err=%b exp 0/1", we_b, err_b); end
      n_cmp++; if (we_a !== 1'b1 || data_a !== 32'h20212223 || err_a !== 1'b0) begin n_bad++; $display("FAIL ovf_big_ok got we=%b %h err=%b exp 1 20212223 0", we_a, data_a, err_a); end
      step();
      n_cmp++; if (nb !== 4 || lb_addr[3] !== 4'd12 || lb_data[3] !== 32'h1C1D1E1F) begin n_bad++; $display("FAIL ovf_writes got n=%0d @%h %h exp 4 @c 1c1d1e1f", nb, lb_addr[3], lb_data[3]); end
      n_cmp++; if (done_b !== 1'b1 || hold_b !== 1'b0 || wc_b !== 3'd4) begin n_bad++; $display("FAIL ovf_run got done=%b hold=%b wc=%0d exp 1/0/4", done_b, hold_b, wc_b); end
   endtask

   task automatic test_restart();
      pulse_start(); nb = 0;
      n_cmp++; if ({err_b, hold_b, done_b, wc_b} !== {3'b010, 3'd0}) begin n_bad++; $display("FAIL restart_clear got err=%b hold=%b done=%b wc=%0d exp 0/1/0/0", err_b, hold_b, done_b, wc_b); end
      send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
      n_cmp++; if ({we_b, addr_b, data_b} !== {1'b1, 4'd0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL restart_w0 got we=%b @%h %h exp 1 @0 deadbeef", we_b, addr_b, data_b); end
      step();
      n_cmp++; if (err_b !== 1'b0 || done_b !== 1'b1) begin n_bad++; $display("FAIL restart_run got err=%b done=%b exp 0/1", err_b, done_b); end
   endtask

   task automatic test_reset_mid();
      pulse_start(); na = 0;
      for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 1'b0);
      reset = 1'b0; byte_in = 8'h16; byte_valid = 1'b1;
      step();
      n_cmp++; if ({hold_a, rdy_a, we_a, done_a, err_a} !== 5'b10000 || wc_a !== 8'd0) begin n_bad++; $display("FAIL mid_reset got hold=%b rdy=%b we=%b done=%b err=%b wc=%0d exp 1/0/0/0/0/0", hold_a, rdy_a, we_a, done_a, err_a, wc_a); end
      reset = 1'b1;
      for (int i = 0; i < 6; i++) step();
      byte_valid = 1'b0;
      n_cmp++; if (na !== 1 || la_data[0] !== 32'h11121314) begin n_bad++; $display("FAIL mid_no_more_writes got n=%0d %h exp 1 11121314", na, la_data[0]); end
      n_cmp++; if (hold_a !== 1'b1 || rdy_a !== 1'b0) begin n_bad++; $display("FAIL mid_idle got hold=%b rdy=%b exp 1/0", hold_a, rdy_a); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_two_words();
      test_padded();
      test_gaps();
      test_overflow();
      test_restart();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
